// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: round-robin sharing of one ALU among NREQ requesters,
// one op in flight, result returned on a single response channel tagged by id.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_cmd/req_din per
// requester; alu_cmdin/alu_din_1..3 to the ALU; alu_dout_low/high, alu_zero,
// alu_error from the ALU; rsp_valid/rsp_ready/rsp_id/rsp_low/rsp_high/
// rsp_zero/rsp_error response channel; busy when not idle.
// Option: define ALU_SCHED_DIVZERO_BYPASS_EN to answer a divide by zero
// immediately with rsp_error=1 instead of issuing it to the ALU.
module alu_req_scheduler #(
   parameter int WIDTH   = 8,
   parameter int NREQ    = 2,
   parameter int ALU_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [6*NREQ-1:0]         req_cmd,
   input  logic [3*WIDTH*NREQ-1:0]   req_din,
   output logic [5:0]                alu_cmdin,
   output logic [WIDTH-1:0]          alu_din_1,
   output logic [WIDTH-1:0]          alu_din_2,
   output logic [WIDTH-1:0]          alu_din_3,
   input  logic [WIDTH-1:0]          alu_dout_low,
   input  logic [WIDTH-1:0]          alu_dout_high,
   input  logic                      alu_zero,
   input  logic                      alu_error,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic [WIDTH-1:0]          rsp_low,
   output logic [WIDTH-1:0]          rsp_high,
   output logic                      rsp_zero,
   output logic                      rsp_error,
   output logic                      busy
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(ALU_LAT + 2);
   localparam int DW  = 3 * WIDTH;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   state_t          state_nx;
   logic [IDW-1:0]  ptr;
   logic [CW-1:0]   cnt;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gidx;
   logic            hit;
   logic [5:0]      cmd_sel;
   logic [DW-1:0]   din_sel;
   logic            bypass;

   // Two passes: indices above the pointer first, then wrap to the low ones.
   always_comb begin
      grant   = '0;
      gidx    = '0;
      hit     = 1'b0;
      cmd_sel = '0;
      din_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!hit && req_valid[i] && (IDW'(i) > ptr)) begin
            grant[i] = 1'b1;
            gidx     = IDW'(i);
            hit      = 1'b1;
            cmd_sel  = req_cmd[i*6 +: 6];
            din_sel  = req_din[i*DW +: DW];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!hit && req_valid[i] && (IDW'(i) <= ptr)) begin
            grant[i] = 1'b1;
            gidx     = IDW'(i);
            hit      = 1'b1;
            cmd_sel  = req_cmd[i*6 +: 6];
            din_sel  = req_din[i*DW +: DW];
         end
      end
   end

`ifdef ALU_SCHED_DIVZERO_BYPASS_EN
   logic [WIDTH-1:0] bop;

   always_comb begin
      case (cmd_sel[3:2])
         2'd1:    bop = din_sel[2*WIDTH-1:WIDTH];
         2'd2:    bop = din_sel[DW-1:2*WIDTH];
         default: bop = din_sel[WIDTH-1:0];
      endcase
   end

   assign bypass = (cmd_sel[1:0] == 2'd3) && (bop == '0);
`else
   assign bypass = 1'b0;
`endif

   assign req_ready = (state == IDLE) ? grant : '0;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (hit) state_nx = bypass ? RESP : WAIT;
         WAIT:    if (cnt == CW'(1)) state_nx = RESP;
         RESP:    if (rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= IDW'(NREQ - 1);
         cnt       <= '0;
         alu_cmdin <= '0;
         alu_din_1 <= '0;
         alu_din_2 <= '0;
         alu_din_3 <= '0;
         rsp_id    <= '0;
         rsp_low   <= '0;
         rsp_high  <= '0;
         rsp_zero  <= 1'b0;
         rsp_error <= 1'b0;
      end else begin
         case (state)
            IDLE: if (hit) begin
               ptr    <= gidx;
               rsp_id <= gidx;
               if (bypass) begin
                  // ALU inputs keep the previous op.
                  rsp_low   <= '0;
                  rsp_high  <= '0;
                  rsp_zero  <= 1'b0;
                  rsp_error <= 1'b1;
               end else begin
                  alu_cmdin <= cmd_sel;
                  alu_din_1 <= din_sel[WIDTH-1:0];
                  alu_din_2 <= din_sel[2*WIDTH-1:WIDTH];
                  alu_din_3 <= din_sel[DW-1:2*WIDTH];
                  cnt       <= CW'(ALU_LAT + 1);
               end
            end
            WAIT: begin
               if (cnt == CW'(1)) begin
                  rsp_low   <= alu_dout_low;
                  rsp_high  <= alu_dout_high;
                  rsp_zero  <= alu_zero;
                  rsp_error <= alu_error;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb_alu_req_scheduler: directed and random checks of alu_req_scheduler
// against a transaction-level model, with a behavioural one-cycle ALU.
module tb_alu_req_scheduler;
   localparam int W = 8;
   localparam int N = 2;
   localparam int L = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [6*N-1:0]   req_cmd;
   logic [3*W*N-1:0] req_din;
   logic [5:0]    alu_cmdin;
   logic [W-1:0]  alu_din_1;
   logic [W-1:0]  alu_din_2;
   logic [W-1:0]  alu_din_3;
   logic [W-1:0]  alu_dout_low = '0;
   logic [W-1:0]  alu_dout_high = '0;
   logic          alu_zero = 1'b0;
   logic          alu_error = 1'b0;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [0:0]    rsp_id;
   logic [W-1:0]  rsp_low;
   logic [W-1:0]  rsp_high;
   logic          rsp_zero;
   logic          rsp_error;
   logic          busy;

   int errs = 0;
   int checks = 0;

   bit         m_busy;
   bit         m_resp;
   int         m_left;
   int         m_last;
   int         e_id;
   logic [7:0] e_low, e_high;
   logic       e_zero, e_err;
   logic [5:0] e_cmd;
   logic [7:0] e_d1, e_d2, e_d3;
   int         gq[$];

   alu_req_scheduler #(.WIDTH(W), .NREQ(N), .ALU_LAT(L)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_din(req_din),
      .alu_cmdin(alu_cmdin), .alu_din_1(alu_din_1),
      .alu_din_2(alu_din_2), .alu_din_3(alu_din_3),
      .alu_dout_low(alu_dout_low), .alu_dout_high(alu_dout_high),
      .alu_zero(alu_zero), .alu_error(alu_error),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_low(rsp_low), .rsp_high(rsp_high),
      .rsp_zero(rsp_zero), .rsp_error(rsp_error), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] opsel(input logic [1:0] s,
         input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
      case (s)
         2'd1:    return d2;
         2'd2:    return d3;
         default: return d1;
      endcase
   endfunction

   // {error, zero, high, low}
   function automatic logic [17:0] alu_f(input logic [5:0] c,
         input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
      logic [7:0]  a, b;
      logic [15:0] r;
      logic        er;
      a  = opsel(c[5:4], d1, d2, d3);
      b  = opsel(c[3:2], d1, d2, d3);
      er = 1'b0;
      case (c[1:0])
         2'd0: r = 16'(a) + 16'(b);
         2'd1: r = 16'(a) - 16'(b);
         2'd2: r = 16'(a) * 16'(b);
         default: begin
            if (b == 8'd0) begin
               r  = 16'd0;
               er = 1'b1;
            end else begin
               r = {a % b, a / b};
            end
         end
      endcase
      return {er, (r == 16'd0) && !er, r};
   endfunction

   always @(posedge clk)
      {alu_error, alu_zero, alu_dout_high, alu_dout_low} <=
         alu_f(alu_cmdin, alu_din_1, alu_din_2, alu_din_3);

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [5:0] c,
         input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
      if (i == 0) begin
         req_cmd[5:0]  = c;
         req_din[23:0] = {d3, d2, d1};
      end else begin
         req_cmd[11:6]  = c;
         req_din[47:24] = {d3, d2, d1};
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_resp = 1'b0;
      m_left = 0;
      m_last = N - 1;
      e_cmd  = '0;
      e_d1   = '0;
      e_d2   = '0;
      e_d3   = '0;
   endtask

   // Check the current cycle, advance the model across the edge, then step.
   task automatic tick();
      int          g;
      logic [N-1:0] e;
      logic [5:0]  c;
      logic [23:0] d;
      bit          byp;
      #3;
      g = m_busy ? -1 : pick(req_valid, m_last);
      e = '0;
      if (g == 0) e = 2'b01;
      if (g == 1) e = 2'b10;
      chk("req_ready", 32'(req_ready), 32'(e));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("alu_cmdin", 32'(alu_cmdin), 32'(e_cmd));
      chk("alu_din_1", 32'(alu_din_1), 32'(e_d1));
      chk("alu_din_2", 32'(alu_din_2), 32'(e_d2));
      chk("alu_din_3", 32'(alu_din_3), 32'(e_d3));
      if (m_resp) begin
         chk("rsp_id", 32'(rsp_id), 32'(e_id));
         chk("rsp_low", 32'(rsp_low), 32'(e_low));
         chk("rsp_high", 32'(rsp_high), 32'(e_high));
         chk("rsp_zero", 32'(rsp_zero), 32'(e_zero));
         chk("rsp_error", 32'(rsp_error), 32'(e_err));
      end
      if (req_ready == 2'b01) gq.push_back(0);
      else if (req_ready == 2'b10) gq.push_back(1);
      else if (req_ready != 2'b00) gq.push_back(9);

      if (rst) begin
         model_reset();
      end else if (g >= 0) begin
         c = (g == 0) ? req_cmd[5:0] : req_cmd[11:6];
         d = (g == 0) ? req_din[23:0] : req_din[47:24];
         m_busy = 1'b1;
         m_last = g;
         e_id   = g;
         byp    = 1'b0;
`ifdef ALU_SCHED_DIVZERO_BYPASS_EN
         byp = (c[1:0] == 2'd3) &&
               (opsel(c[3:2], d[7:0], d[15:8], d[23:16]) == 8'd0);
`endif
         if (byp) begin
            {e_err, e_zero, e_high, e_low} = {1'b1, 1'b0, 16'd0};
            m_resp = 1'b1;
         end else begin
            e_cmd = c;
            e_d1  = d[7:0];
            e_d2  = d[15:8];
            e_d3  = d[23:16];
            {e_err, e_zero, e_high, e_low} = alu_f(c, e_d1, e_d2, e_d3);
            m_left = L + 1;
         end
      end else if (m_busy && !m_resp) begin
         m_left--;
         if (m_left == 0) m_resp = 1'b1;
      end else if (m_resp && rsp_ready) begin
         m_resp = 1'b0;
         m_busy = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_cmd   = '0;
      req_din   = '0;
      rsp_ready = 1'b0;
      e_id      = 0;
      {e_err, e_zero, e_high, e_low} = '0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rvalid", 32'(rsp_valid), 32'd0);
      chk("rst_cmd", 32'(alu_cmdin), 32'd0);
      chk("rst_din", 32'({alu_din_3, alu_din_2, alu_din_1}), 32'd0);
      chk("rst_rsp", 32'({rsp_id, rsp_high, rsp_low, rsp_zero, rsp_error}), 32'd0);
      rst = 1'b0;

      // add: 3 + 4
      set_req(0, 6'd4, 8'd3, 8'd4, 8'd0);
      req_valid = 2'b01;
      rsp_ready = 1'b1;
      #1 chk("t2_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = '0;
      tick();
      chk("t2_early", 32'(rsp_valid), 32'd0);
      tick();
      chk("t2_valid", 32'(rsp_valid), 32'd1);
      chk("t2_id", 32'(rsp_id), 32'd0);
      chk("t2_low", 32'(rsp_low), 32'd7);
      chk("t2_high", 32'(rsp_high), 32'd0);
      chk("t2_flags", 32'({rsp_zero, rsp_error}), 32'd0);
      tick();
      chk("t2_done", 32'(rsp_valid), 32'd0);

      // continuous requests from both: strict rotation
      do_reset();
      set_req(0, 6'd0, 8'd10, 8'd20, 8'd30);
      set_req(1, 6'd1, 8'd50, 8'd7, 8'd1);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      gq.delete();
      repeat (4 * (L + 3)) tick();
      req_valid = '0;
      chk("t3_n", 32'(gq.size()), 32'd4);
      chk("t3_g0", 32'(gq[0]), 32'd0);
      chk("t3_g1", 32'(gq[1]), 32'd1);
      chk("t3_g2", 32'(gq[2]), 32'd0);
      chk("t3_g3", 32'(gq[3]), 32'd1);

      // mul 80*5 held under backpressure
      set_req(1, 6'd6, 8'd80, 8'd5, 8'd0);
      req_valid = 2'b10;
      rsp_ready = 1'b0;
      tick();
      req_valid = '0;
      tick();
      tick();
      set_req(0, 6'd4, 8'd1, 8'd1, 8'd1);
      req_valid = 2'b01;
      repeat (5) begin
         #1;
         chk("t4_valid", 32'(rsp_valid), 32'd1);
         chk("t4_ready", 32'(req_ready), 32'd0);
         chk("t4_low", 32'(rsp_low), 32'd144);
         chk("t4_high", 32'(rsp_high), 32'd1);
         chk("t4_id", 32'(rsp_id), 32'd1);
         tick();
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      tick();
      chk("t4_done", 32'(rsp_valid), 32'd0);

      // div by din_3 = 0
      set_req(0, 6'd11, 8'd9, 8'd3, 8'd0);
      req_valid = 2'b01;
      rsp_ready = 1'b0;
      tick();
      req_valid = '0;
`ifdef ALU_SCHED_DIVZERO_BYPASS_EN
      chk("t5_valid", 32'(rsp_valid), 32'd1);
      chk("t5_cmd", 32'(alu_cmdin), 32'd6);
      chk("t5_low", 32'({rsp_high, rsp_low}), 32'd0);
      chk("t5_zero", 32'(rsp_zero), 32'd0);
`else
      chk("t5_early", 32'(rsp_valid), 32'd0);
      tick();
      tick();
      chk("t5_valid", 32'(rsp_valid), 32'd1);
      chk("t5_cmd", 32'(alu_cmdin), 32'd11);
`endif
      chk("t5_err", 32'(rsp_error), 32'd1);
      rsp_ready = 1'b1;
      tick();
      chk("t5_done", 32'(rsp_valid), 32'd0);

      // reset while waiting on the ALU
      set_req(1, 6'd4, 8'd1, 8'd2, 8'd3);
      req_valid = 2'b10;
      tick();
      req_valid = '0;
      chk("t6_wait", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_rvalid", 32'(rsp_valid), 32'd0);
      req_valid = 2'b11;
      #1 chk("t6_first", 32'(req_ready), 32'd1);
      tick();
      req_valid = '0;
      repeat (L + 3) tick();

      for (int n = 0; n < 500; n++) begin
         rst       = ($urandom_range(0, 59) == 0);
         req_valid = 2'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 7);
         for (int r = 0; r < N; r++)
            set_req(r, 6'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
